// File: rtl/drm_request_scheduler.sv
// drm_request_scheduler: shares the DDR command port between four slow-domain requesters and a refresh timer
module drm_request_scheduler #(
  parameter int ADDR_WIDTH        = 24,
  parameter int REFRESH_PERIOD    = 1000,
  parameter int REFRESH_CNT_WIDTH = 10
) (
  input  logic                    int_logic_drm_clock_buffered,
  input  logic                    int_reset,
  input  logic                    cke_gl_to_drm,
  input  logic                    cke_drm_to_gl,
  input  logic [3:0]              req,
  input  logic [3:0]              req_write,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  output logic [3:0]              ack,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_refresh,
  output logic                    cmd_write,
  output logic [ADDR_WIDTH-1:0]   cmd_addr,
  output logic [1:0]              cmd_id,
  input  logic                    cmd_done,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK_WAIT} state_t;
  state_t state_q, state_d;
  logic [1:0] rr_q, rr_d, cmd_id_q, cmd_id_d, gnt;
  logic [REFRESH_CNT_WIDTH-1:0] ref_cnt_q, ref_cnt_d;
  logic ref_pend_q, ref_pend_d, ack_pend_q, ack_pend_d;
  logic cmd_valid_q, cmd_valid_d, cmd_refresh_q, cmd_refresh_d, cmd_write_q, cmd_write_d;
  logic busy_q, busy_d, gnt_found, expire;
  logic [3:0] ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  always_comb begin
    gnt_found = 1'b0;
    gnt = rr_q;
    for (int k = 3; k >= 0; k--)
      if (req[rr_q + 2'(k)]) begin
        gnt_found = 1'b1;
        gnt = rr_q + 2'(k);
      end
  end
  always_comb begin
    expire = ref_cnt_q == REFRESH_CNT_WIDTH'(REFRESH_PERIOD - 1);
    ref_cnt_d = expire ? '0 : ref_cnt_q + REFRESH_CNT_WIDTH'(1);
    ref_pend_d = expire | (ref_pend_q & ~(cmd_valid_q & cmd_ready & cmd_refresh_q));
    state_d = state_q;
    rr_d = rr_q;
    ack_pend_d = ack_pend_q;
    ack_d = ack_q;
    cmd_valid_d = cmd_valid_q;
    cmd_refresh_d = cmd_refresh_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d = cmd_addr_q;
    cmd_id_d = cmd_id_q;
    case (state_q)
      IDLE:
        if (ref_pend_q) begin
          state_d = ISSUE;
          cmd_valid_d = 1'b1;
          cmd_refresh_d = 1'b1;
          cmd_write_d = 1'b0;
          cmd_addr_d = '0;
          cmd_id_d = '0;
        end else if (cke_gl_to_drm && gnt_found) begin
          state_d = ISSUE;
          cmd_valid_d = 1'b1;
          cmd_refresh_d = 1'b0;
          cmd_write_d = req_write[gnt];
          cmd_addr_d = req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
          cmd_id_d = gnt;
          rr_d = gnt + 2'd1;
        end
      ISSUE:
        if (cmd_ready) begin
          state_d = WAIT_DONE;
          cmd_valid_d = 1'b0;
        end
      WAIT_DONE:
        if (cmd_done) begin
          state_d = cmd_refresh_q ? IDLE : ACK_WAIT;
          ack_pend_d = ~cmd_refresh_q;
        end
      ACK_WAIT:
        if (cke_drm_to_gl) begin
          if (ack_pend_q) begin
            ack_d[cmd_id_q] = 1'b1;
            ack_pend_d = 1'b0;
          end else begin
            ack_d = '0;
            state_d = IDLE;
          end
        end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge int_logic_drm_clock_buffered) begin
    if (int_reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      ref_cnt_q <= '0;
      ref_pend_q <= 1'b0;
      ack_pend_q <= 1'b0;
      ack_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_refresh_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q <= '0;
      cmd_id_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      ref_cnt_q <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ack_pend_q <= ack_pend_d;
      ack_q <= ack_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_refresh_q <= cmd_refresh_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_id_q <= cmd_id_d;
      busy_q <= busy_d;
    end
  end
  assign ack = ack_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_refresh = cmd_refresh_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_id = cmd_id_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_drm_request_scheduler.sv
// tb_drm_request_scheduler: directed checks of grant, refresh, backpressure, cke gating and reset behaviour
module tb_drm_request_scheduler;
  localparam int AW = 24;
  typedef struct {
    logic r;
    logic w;
    logic [AW-1:0] a;
    logic [1:0] id;
  } cmd_t;
  logic clk = 1'b0;
  logic rst, cke_gl, cke_drm, cmd_ready, cmd_done, cmd_valid, cmd_refresh, cmd_write, busy;
  logic [3:0] req, req_write, ack;
  logic [4*AW-1:0] req_addr;
  logic [AW-1:0] cmd_addr;
  logic [1:0] cmd_id;
  int n_chk, n_err, e, rst_e, gl_e, ph, dc, done_dly, gl_since_done, last_gsd;
  int ack_rise_e, ack_obs, ack_run, ack_len, n_req_cmd, last_rise_e, first_ref_e, k;
  bit gl_en, rr_mode;
  logic prev_valid;
  logic [3:0] prev_ack;
  logic [1:0] rr_exp [5];
  cmd_t log_q[$];
  always #5 clk = ~clk;
  drm_request_scheduler #(.ADDR_WIDTH(AW), .REFRESH_PERIOD(16), .REFRESH_CNT_WIDTH(4)) dut (
    .int_logic_drm_clock_buffered(clk),
    .int_reset(rst),
    .cke_gl_to_drm(cke_gl),
    .cke_drm_to_gl(cke_drm),
    .req(req),
    .req_write(req_write),
    .req_addr(req_addr),
    .ack(ack),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_refresh(cmd_refresh),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_id(cmd_id),
    .cmd_done(cmd_done),
    .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask
  task automatic step();
    bit acc, gl, dn;
    cmd_t c;
    ph++;
    gl = gl_en && (ph % 8 == 0);
    cke_gl = gl;
    cke_drm = (ph % 8 == 4);
    if (dc > 0) begin
      dc--;
      cmd_done = (dc == 0);
    end else cmd_done = 1'b0;
    dn = cmd_done;
    acc = (cmd_valid === 1'b1) && cmd_ready && !rst;
    c.r = cmd_refresh;
    c.w = cmd_write;
    c.a = cmd_addr;
    c.id = cmd_id;
    @(posedge clk);
    #1;
    e++;
    if (acc) begin
      log_q.push_back(c);
      dc = done_dly;
    end
    if (dn) gl_since_done = 0;
    if (gl && !dn) gl_since_done++;
    if (gl) gl_e = e;
    if (cmd_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (cmd_refresh) begin
        if (first_ref_e < 0) first_ref_e = e;
      end else begin
        n_req_cmd++;
        last_rise_e = e;
        last_gsd = gl_since_done;
        check("grant_latency", e, gl_e);
      end
    end
    if (ack !== 4'b0) begin
      ack_obs++;
      ack_run++;
      if (prev_ack === 4'b0) ack_rise_e = e;
    end else if (ack_run > 0) begin
      ack_len = ack_run;
      ack_run = 0;
    end
    for (int i = 0; i < 4; i++)
      if (ack[i] === 1'b1) req[i] = 1'b0;
      else if (prev_ack[i] === 1'b1 && rr_mode) req[i] = 1'b1;
    prev_valid = cmd_valid;
    prev_ack = ack;
  endtask
  task automatic do_reset(input bit keep_done);
    rst = 1'b1;
    req = '0;
    req_write = '0;
    req_addr = '0;
    gl_en = 1'b1;
    rr_mode = 1'b0;
    cmd_ready = 1'b1;
    done_dly = 3;
    if (!keep_done) dc = 0;
    ph = 0;
    step();
    rst = 1'b0;
    rst_e = e;
    log_q.delete();
    n_req_cmd = 0;
    ack_obs = 0;
    ack_run = 0;
    ack_len = 0;
    ack_rise_e = -1;
    first_ref_e = -1;
    last_rise_e = -1;
    last_gsd = -1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    n_chk = 0;
    n_err = 0;
    e = 0;
    dc = 0;
    gl_e = -1;
    prev_valid = 1'b0;
    prev_ack = '0;
    cmd_done = 1'b0;
    rr_exp[0] = 2'd0;
    rr_exp[1] = 2'd1;
    rr_exp[2] = 2'd2;
    rr_exp[3] = 2'd3;
    rr_exp[4] = 2'd0;
    do_reset(0);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_refresh", cmd_refresh, 0);
    check("rst_write", cmd_write, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_id", cmd_id, 0);
    req_addr[0 +: AW] = 24'h000123;
    req = 4'b0001;
    repeat (7) step();
    check("rd_valid", cmd_valid, 1);
    check("rd_busy", busy, 1);
    check("rd_addr", cmd_addr, 24'h000123);
    check("rd_id", cmd_id, 0);
    check("rd_write", cmd_write, 0);
    check("rd_refresh", cmd_refresh, 0);
    check("rd_rise_edge", last_rise_e - rst_e, 7);
    repeat (22) step();
    check("rd_ack_rise", ack_rise_e - rst_e, 19);
    check("rd_ack_len", ack_len, 8);
    check("rd_ack_obs", ack_obs, 8);
    check("rd_log_size", log_q.size(), 2);
    check("rd_log_id", log_q[0].id, 0);
    check("rd_log_ref", log_q[1].r, 1);
    check("rd_ref_after_ack", first_ref_e - rst_e, 28);
    do_reset(0);
    rr_mode = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 600 && n_req_cmd < 5; i++) step();
    repeat (2) step();
    check("rr_grants", n_req_cmd >= 5, 1);
    k = 0;
    foreach (log_q[i])
      if (!log_q[i].r && k < 5) begin
        check($sformatf("rr_id%0d", k), log_q[i].id, rr_exp[k]);
        k++;
      end
    check("rr_count", k, 5);
    do_reset(0);
    req_addr[AW +: AW] = 24'h00BEEF;
    req = 4'b0010;
    gl_en = 1'b0;
    repeat (16) step();
    gl_en = 1'b1;
    repeat (20) step();
    check("ref_first_edge", first_ref_e - rst_e, 17);
    check("ref_log_size", log_q.size(), 2);
    check("ref_is_refresh", log_q[0].r, 1);
    check("ref_addr", log_q[0].a, 0);
    check("ref_write", log_q[0].w, 0);
    check("ref_then_req", log_q[1].r, 0);
    check("ref_then_id", log_q[1].id, 1);
    check("ref_then_addr", log_q[1].a, 24'h00BEEF);
    check("ref_next_cke", last_gsd, 1);
    check("ref_req_edge", last_rise_e - rst_e, 23);
    do_reset(0);
    cmd_ready = 1'b0;
    req_write = 4'b0100;
    req_addr[2*AW +: AW] = 24'hABCDEF;
    req = 4'b0100;
    repeat (7) step();
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", cmd_valid, 1);
      check("bp_fields", {cmd_refresh, cmd_write, cmd_id, cmd_addr}, {1'b0, 1'b1, 2'd2, 24'hABCDEF});
      step();
    end
    check("bp_valid21", cmd_valid, 1);
    cmd_ready = 1'b1;
    step();
    check("bp_dropped", cmd_valid, 0);
    check("bp_busy", busy, 1);
    check("bp_one_grant", n_req_cmd, 1);
    check("bp_log_size", log_q.size(), 1);
    check("bp_log", {log_q[0].r, log_q[0].w, log_q[0].id, log_q[0].a}, {1'b0, 1'b1, 2'd2, 24'hABCDEF});
    do_reset(0);
    gl_en = 1'b0;
    req_addr[0 +: AW] = 24'h000777;
    req = 4'b0001;
    repeat (30) step();
    check("gate_no_grant", n_req_cmd, 0);
    check("gate_only_refresh", log_q.size(), 1);
    gl_en = 1'b1;
    for (int i = 0; i < 20 && n_req_cmd == 0; i++) step();
    check("gate_granted", n_req_cmd, 1);
    check("gate_edge", last_rise_e - rst_e, 31);
    check("gate_addr", cmd_addr, 24'h000777);
    do_reset(0);
    done_dly = 10;
    req_addr[0 +: AW] = 24'h000555;
    req = 4'b0001;
    repeat (10) step();
    check("wd_busy", busy, 1);
    check("wd_valid", cmd_valid, 0);
    check("wd_addr", cmd_addr, 24'h000555);
    do_reset(1);
    check("wdr_valid", cmd_valid, 0);
    check("wdr_busy", busy, 0);
    check("wdr_ack", ack, 0);
    check("wdr_addr", cmd_addr, 0);
    check("wdr_id", cmd_id, 0);
    repeat (25) step();
    check("wdr_no_ack", ack_obs, 0);
    check("wdr_no_req", n_req_cmd, 0);
    check("wdr_ref_restart", first_ref_e - rst_e, 17);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
